// File: rtl/riscv_ctrl_pkg.sv
// Shared definitions for the RISC-V decode-stage control unit.
// Holds opcode and funct7 constants, ALU select codes, result-source
// encodings, the MUL/DIV sequencer state enum and the func3 -> ALU helper.
package riscv_ctrl_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_SUB   = 4'b0001;
    localparam logic [3:0] ALU_SLT   = 4'b0010;
    localparam logic [3:0] ALU_SLTU  = 4'b0011;
    localparam logic [3:0] ALU_SLL   = 4'b0100;
    localparam logic [3:0] ALU_SRL   = 4'b0101;
    localparam logic [3:0] ALU_SRA   = 4'b0110;
    localparam logic [3:0] ALU_AND   = 4'b1000;
    localparam logic [3:0] ALU_OR    = 4'b1001;
    localparam logic [3:0] ALU_XOR   = 4'b1010;
    localparam logic [3:0] ALU_PASSB = 4'b1111;

    localparam logic [1:0] RES_ALU    = 2'b00;
    localparam logic [1:0] RES_MEM    = 2'b01;
    localparam logic [1:0] RES_PC4    = 2'b10;
    localparam logic [1:0] RES_MULDIV = 2'b11;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_MD_WAIT = 1'b1
    } ctrl_state_t;

    // alt selects SUB/SRA; it only has an effect for func3 000 and 101.
    function automatic logic [3:0] alu_from_f3(input logic [2:0] f3, input logic alt);
        logic [3:0] sel;
        case (f3)
            3'b000:  sel = alt ? ALU_SUB : ALU_ADD;
            3'b001:  sel = ALU_SLL;
            3'b010:  sel = ALU_SLT;
            3'b011:  sel = ALU_SLTU;
            3'b100:  sel = ALU_XOR;
            3'b101:  sel = alt ? ALU_SRA : ALU_SRL;
            3'b110:  sel = ALU_OR;
            default: sel = ALU_AND;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/control_unit_pipe_if.sv
// Bus between decode/execute pipeline logic and the control unit.
// Carries the decode-stage instruction fields, the E-stage pipeline
// controls, the ID/EX control bundle and the MUL/DIV start/done/ack/abort
// handshake. master = pipeline side, slave = control unit.
interface control_unit_pipe_if #(
    parameter int ALUSEL_W = 4
);
    logic                valid_d;
    logic [6:0]          opcode;
    logic [2:0]          func3;
    logic [6:0]          func7;
    logic [4:0]          rd_d;
    logic                stall_e;
    logic                flush_e;
    logic                muldiv_done;

    logic                muldiv_start;
    logic                muldiv_ack;
    logic                muldiv_abort;
    logic                stall_d;
    logic                valid_e;
    logic                regwrite_e;
    logic                memwrite_e;
    logic                alusrc_e;
    logic                jump_e;
    logic                branch_e;
    logic                illegal_e;
    logic [1:0]          resultsrc_e;
    logic [ALUSEL_W-1:0] alusel_e;
    logic [2:0]          branchop_e;
    logic [4:0]          rd_e;

    modport master (
        output valid_d, opcode, func3, func7, rd_d, stall_e, flush_e, muldiv_done,
        input  muldiv_start, muldiv_ack, muldiv_abort, stall_d,
        input  valid_e, regwrite_e, memwrite_e, alusrc_e, jump_e, branch_e,
        input  illegal_e, resultsrc_e, alusel_e, branchop_e, rd_e
    );

    modport slave (
        input  valid_d, opcode, func3, func7, rd_d, stall_e, flush_e, muldiv_done,
        output muldiv_start, muldiv_ack, muldiv_abort, stall_d,
        output valid_e, regwrite_e, memwrite_e, alusrc_e, jump_e, branch_e,
        output illegal_e, resultsrc_e, alusel_e, branchop_e, rd_e
    );
endinterface

// File: rtl/control_unit_pipe_main_decoder.sv
// Purely combinational RV32I (+ optional M) main decoder.
// Ports: i_opcode/i_func3/i_func7 instruction fields in; o_* control
// bundle out, plus o_is_muldiv flagging a legal M-extension op.
module main_decoder
    import riscv_ctrl_pkg::*;
#(
    parameter int ALUSEL_W  = 4,
    parameter bit EN_MULDIV = 1'b1,
    parameter bit EN_JUMP   = 1'b1
) (
    input  logic [6:0]          i_opcode,
    input  logic [2:0]          i_func3,
    input  logic [6:0]          i_func7,
    output logic                o_regwrite,
    output logic                o_memwrite,
    output logic                o_alusrc,
    output logic                o_jump,
    output logic                o_branch,
    output logic                o_illegal,
    output logic [1:0]          o_resultsrc,
    output logic [ALUSEL_W-1:0] o_alusel,
    output logic [2:0]          o_branchop,
    output logic                o_is_muldiv
);

    logic w_bad;

    always_comb begin
        o_regwrite  = 1'b0;
        o_memwrite  = 1'b0;
        o_alusrc    = 1'b0;
        o_jump      = 1'b0;
        o_branch    = 1'b0;
        o_illegal   = 1'b0;
        o_resultsrc = RES_ALU;
        o_alusel    = ALUSEL_W'(ALU_ADD);
        o_branchop  = 3'b000;
        o_is_muldiv = 1'b0;
        w_bad       = 1'b0;

        case (i_opcode)
            OP_R: begin
                o_regwrite = 1'b1;
                if (i_func7 == F7_BASE) begin
                    o_alusel = ALUSEL_W'(alu_from_f3(i_func3, 1'b0));
                end else if (i_func7 == F7_ALT) begin
                    o_alusel = ALUSEL_W'(alu_from_f3(i_func3, 1'b1));
                end else if (EN_MULDIV && (i_func7 == F7_MULDIV)) begin
                    o_is_muldiv = 1'b1;
                    o_resultsrc = RES_MULDIV;
                end else begin
                    w_bad    = 1'b1;
                    o_alusel = ALUSEL_W'(alu_from_f3(i_func3, 1'b0));
                end
            end
            OP_I: begin
                o_alusrc   = 1'b1;
                o_regwrite = 1'b1;
                // addi has no func7; only the shift encodings borrow it.
                o_alusel   = ALUSEL_W'(alu_from_f3(i_func3,
                                 (i_func3 == 3'b101) && (i_func7 == F7_ALT)));
                if ((i_func3 == 3'b001) && (i_func7 != F7_BASE))
                    w_bad = 1'b1;
                if ((i_func3 == 3'b101) && (i_func7 != F7_BASE) && (i_func7 != F7_ALT))
                    w_bad = 1'b1;
            end
            OP_LOAD: begin
                o_alusrc    = 1'b1;
                o_resultsrc = RES_MEM;
                o_regwrite  = 1'b1;
            end
            OP_STORE: begin
                o_alusrc   = 1'b1;
                o_memwrite = 1'b1;
            end
            OP_BRANCH: begin
                o_alusel   = ALUSEL_W'(ALU_SUB);
                o_branch   = 1'b1;
                o_branchop = i_func3;
                if ((i_func3 == 3'b010) || (i_func3 == 3'b011))
                    w_bad = 1'b1;
            end
            OP_JAL: begin
                if (EN_JUMP) begin
                    o_jump      = 1'b1;
                    o_resultsrc = RES_PC4;
                    o_regwrite  = 1'b1;
                end else begin
                    w_bad = 1'b1;
                end
            end
            OP_JALR: begin
                if (EN_JUMP) begin
                    o_jump      = 1'b1;
                    o_alusrc    = 1'b1;
                    o_resultsrc = RES_PC4;
                    o_regwrite  = 1'b1;
                end else begin
                    w_bad = 1'b1;
                end
            end
            OP_LUI: begin
                o_alusel   = ALUSEL_W'(ALU_PASSB);
                o_alusrc   = 1'b1;
                o_regwrite = 1'b1;
            end
            default: w_bad = 1'b1;
        endcase

        // Illegal ops keep their other decoded fields but must never
        // modify architectural state.
        if (w_bad) begin
            o_illegal   = 1'b1;
            o_regwrite  = 1'b0;
            o_memwrite  = 1'b0;
            o_is_muldiv = 1'b0;
        end
    end

endmodule

// File: rtl/control_unit_pipe.sv
// Decode-stage control unit: main decoder, ID/EX control register with
// stall/flush, and the MUL/DIV start/done/ack/abort sequencer.
// Ports: i_clk, i_reset (synchronous, active high); bus (slave modport)
// carrying decode fields, stall_e/flush_e, MUL/DIV handshake and the
// registered E-stage control bundle.
//
// state      | meaning
// -----------+-----------------------------------------------------
// ST_IDLE    | no MUL/DIV in flight; decode flows normally
// ST_MD_WAIT | MUL/DIV launched; decode held until done is accepted
module control_unit_pipe
    import riscv_ctrl_pkg::*;
#(
    parameter int ALUSEL_W  = 4,
    parameter bit EN_MULDIV = 1'b1,
    parameter bit EN_JUMP   = 1'b1
) (
    input  logic                i_clk,
    input  logic                i_reset,
    control_unit_pipe_if.slave  bus
);

    logic                w_dec_regwrite, w_dec_memwrite, w_dec_alusrc;
    logic                w_dec_jump, w_dec_branch, w_dec_illegal, w_dec_is_muldiv;
    logic [1:0]          w_dec_resultsrc;
    logic [ALUSEL_W-1:0] w_dec_alusel;
    logic [2:0]          w_dec_branchop;

    main_decoder #(
        .ALUSEL_W  (ALUSEL_W),
        .EN_MULDIV (EN_MULDIV),
        .EN_JUMP   (EN_JUMP)
    ) u_dec (
        .i_opcode    (bus.opcode),
        .i_func3     (bus.func3),
        .i_func7     (bus.func7),
        .o_regwrite  (w_dec_regwrite),
        .o_memwrite  (w_dec_memwrite),
        .o_alusrc    (w_dec_alusrc),
        .o_jump      (w_dec_jump),
        .o_branch    (w_dec_branch),
        .o_illegal   (w_dec_illegal),
        .o_resultsrc (w_dec_resultsrc),
        .o_alusel    (w_dec_alusel),
        .o_branchop  (w_dec_branchop),
        .o_is_muldiv (w_dec_is_muldiv)
    );

    ctrl_state_t r_state, w_state_nxt;
    logic [4:0]  r_md_rd;
    logic        w_start, w_ack, w_abort, w_stall_d;

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_ack       = 1'b0;
        w_abort     = 1'b0;
        w_stall_d   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // Hold decode on an M-op even when E cannot accept the
                // launch yet, so the op is not lost.
                if (bus.valid_d && w_dec_is_muldiv) begin
                    w_stall_d = 1'b1;
                    if (!bus.stall_e && !bus.flush_e) begin
                        w_start     = 1'b1;
                        w_state_nxt = ST_MD_WAIT;
                    end
                end
            end
            ST_MD_WAIT: begin
                w_stall_d = 1'b1;
                if (bus.flush_e) begin
                    w_abort     = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else if (bus.muldiv_done && !bus.stall_e) begin
                    w_ack       = 1'b1;
                    w_stall_d   = 1'b0;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Reset suppresses every handshake pulse, including from MD_WAIT.
    assign bus.muldiv_start = w_start   & ~i_reset;
    assign bus.muldiv_ack   = w_ack     & ~i_reset;
    assign bus.muldiv_abort = w_abort   & ~i_reset;
    assign bus.stall_d      = w_stall_d & ~i_reset;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
            r_md_rd <= 5'd0;
        end else begin
            r_state <= w_state_nxt;
            if (w_start)
                r_md_rd <= bus.rd_d;
        end
    end

    logic                w_nxt_valid, w_nxt_regwrite, w_nxt_memwrite, w_nxt_alusrc;
    logic                w_nxt_jump, w_nxt_branch, w_nxt_illegal;
    logic [1:0]          w_nxt_resultsrc;
    logic [ALUSEL_W-1:0] w_nxt_alusel;
    logic [2:0]          w_nxt_branchop;
    logic [4:0]          w_nxt_rd;

    always_comb begin
        w_nxt_valid     = 1'b0;
        w_nxt_regwrite  = 1'b0;
        w_nxt_memwrite  = 1'b0;
        w_nxt_alusrc    = 1'b0;
        w_nxt_jump      = 1'b0;
        w_nxt_branch    = 1'b0;
        w_nxt_illegal   = 1'b0;
        w_nxt_resultsrc = RES_ALU;
        w_nxt_alusel    = '0;
        w_nxt_branchop  = 3'b000;
        w_nxt_rd        = 5'd0;
        if (w_ack) begin
            // Completed MUL/DIV writes back from the MUL/DIV result port.
            w_nxt_valid     = 1'b1;
            w_nxt_regwrite  = 1'b1;
            w_nxt_resultsrc = RES_MULDIV;
            w_nxt_rd        = r_md_rd;
        end else if (bus.valid_d && !w_stall_d) begin
            w_nxt_valid     = 1'b1;
            w_nxt_regwrite  = w_dec_regwrite;
            w_nxt_memwrite  = w_dec_memwrite;
            w_nxt_alusrc    = w_dec_alusrc;
            w_nxt_jump      = w_dec_jump;
            w_nxt_branch    = w_dec_branch;
            w_nxt_illegal   = w_dec_illegal;
            w_nxt_resultsrc = w_dec_resultsrc;
            w_nxt_alusel    = w_dec_alusel;
            w_nxt_branchop  = w_dec_branchop;
            w_nxt_rd        = bus.rd_d;
        end
    end

    logic                r_valid_e, r_regwrite_e, r_memwrite_e, r_alusrc_e;
    logic                r_jump_e, r_branch_e, r_illegal_e;
    logic [1:0]          r_resultsrc_e;
    logic [ALUSEL_W-1:0] r_alusel_e;
    logic [2:0]          r_branchop_e;
    logic [4:0]          r_rd_e;

    always_ff @(posedge i_clk) begin
        if (i_reset || bus.flush_e) begin
            r_valid_e     <= 1'b0;
            r_regwrite_e  <= 1'b0;
            r_memwrite_e  <= 1'b0;
            r_alusrc_e    <= 1'b0;
            r_jump_e      <= 1'b0;
            r_branch_e    <= 1'b0;
            r_illegal_e   <= 1'b0;
            r_resultsrc_e <= 2'b00;
            r_alusel_e    <= '0;
            r_branchop_e  <= 3'b000;
            r_rd_e        <= 5'd0;
        end else if (!bus.stall_e) begin
            r_valid_e     <= w_nxt_valid;
            r_regwrite_e  <= w_nxt_regwrite;
            r_memwrite_e  <= w_nxt_memwrite;
            r_alusrc_e    <= w_nxt_alusrc;
            r_jump_e      <= w_nxt_jump;
            r_branch_e    <= w_nxt_branch;
            r_illegal_e   <= w_nxt_illegal;
            r_resultsrc_e <= w_nxt_resultsrc;
            r_alusel_e    <= w_nxt_alusel;
            r_branchop_e  <= w_nxt_branchop;
            r_rd_e        <= w_nxt_rd;
        end
    end

    assign bus.valid_e     = r_valid_e;
    assign bus.regwrite_e  = r_regwrite_e;
    assign bus.memwrite_e  = r_memwrite_e;
    assign bus.alusrc_e    = r_alusrc_e;
    assign bus.jump_e      = r_jump_e;
    assign bus.branch_e    = r_branch_e;
    assign bus.illegal_e   = r_illegal_e;
    assign bus.resultsrc_e = r_resultsrc_e;
    assign bus.alusel_e    = r_alusel_e;
    assign bus.branchop_e  = r_branchop_e;
    assign bus.rd_e        = r_rd_e;

endmodule

// File: tb/tb_control_unit_pipe.sv
module tb_control_unit_pipe;

    localparam bit EN_MULDIV = 1'b1;
    localparam bit EN_JUMP   = 1'b1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    control_unit_pipe_if #(.ALUSEL_W(4)) bus ();

    control_unit_pipe #(
        .ALUSEL_W  (4),
        .EN_MULDIV (EN_MULDIV),
        .EN_JUMP   (EN_JUMP)
    ) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    typedef struct packed {
        logic       v, rw, mw, src, j, b, il;
        logic [1:0] rs;
        logic [3:0] alu;
        logic [2:0] bo;
        logic [4:0] rd;
    } bundle_t;

    typedef struct {
        logic       vd;
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        logic [4:0] rd;
        bundle_t    exp;
    } vec_t;

    int n_checks = 0;
    int n_errors = 0;

    vec_t vq[$];
    logic [3:0] alu_tab [8] = '{4'h0, 4'h4, 4'h2, 4'h3, 4'hA, 4'h5, 4'h9, 4'h8};

    bundle_t    m_e;
    bit         m_busy;
    logic [4:0] m_rd;
    bit         s_start, s_ack, s_abort, s_stall_d;
    bit         u_busy;
    int         u_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bundle_t mk(input logic v, rw, mw, src, j, b, il,
                                   input logic [1:0] rs, input logic [3:0] alu,
                                   input logic [2:0] bo, input logic [4:0] rd);
        bundle_t r;
        r.v = v; r.rw = rw; r.mw = mw; r.src = src; r.j = j; r.b = b; r.il = il;
        r.rs = rs; r.alu = alu; r.bo = bo; r.rd = rd;
        return r;
    endfunction

    function automatic void addv(input logic vd, input logic [6:0] op, input logic [2:0] f3,
                                 input logic [6:0] f7, input logic [4:0] rd, input bundle_t exp);
        vec_t t;
        t.vd = vd; t.op = op; t.f3 = f3; t.f7 = f7; t.rd = rd; t.exp = exp;
        vq.push_back(t);
    endfunction

    function automatic bundle_t get_e();
        bundle_t g;
        g.v = bus.valid_e; g.rw = bus.regwrite_e; g.mw = bus.memwrite_e;
        g.src = bus.alusrc_e; g.j = bus.jump_e; g.b = bus.branch_e;
        g.il = bus.illegal_e; g.rs = bus.resultsrc_e; g.alu = bus.alusel_e;
        g.bo = bus.branchop_e; g.rd = bus.rd_e;
        return g;
    endfunction

    // Reference decode straight from the instruction-set rules.
    function automatic bundle_t ref_decode(input logic [6:0] op, input logic [2:0] f3,
                                           input logic [6:0] f7, input logic [4:0] rd);
        bundle_t r = '0;
        bit bad = 1'b0;
        r.v = 1'b1;
        r.rd = rd;
        case (op)
            7'h33: begin
                r.rw = 1'b1;
                r.alu = alu_tab[f3];
                if (f7 == 7'h20 && f3 == 3'd0) r.alu = 4'h1;
                if (f7 == 7'h20 && f3 == 3'd5) r.alu = 4'h6;
                bad = !(f7 == 7'h00 || f7 == 7'h20 || (EN_MULDIV && f7 == 7'h01));
            end
            7'h13: begin
                r.src = 1'b1; r.rw = 1'b1;
                r.alu = alu_tab[f3];
                if (f3 == 3'd5 && f7 == 7'h20) r.alu = 4'h6;
                if (f3 == 3'd1 && f7 != 7'h00) bad = 1'b1;
                if (f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20) bad = 1'b1;
            end
            7'h03: begin r.src = 1'b1; r.rs = 2'b01; r.rw = 1'b1; end
            7'h23: begin r.src = 1'b1; r.mw = 1'b1; end
            7'h63: begin
                r.alu = 4'h1; r.b = 1'b1; r.bo = f3;
                bad = (f3 == 3'd2 || f3 == 3'd3);
            end
            7'h6f: if (EN_JUMP) begin r.j = 1'b1; r.rs = 2'b10; r.rw = 1'b1; end else bad = 1'b1;
            7'h67: if (EN_JUMP) begin r.j = 1'b1; r.src = 1'b1; r.rs = 2'b10; r.rw = 1'b1; end
                   else bad = 1'b1;
            7'h37: begin r.alu = 4'hF; r.src = 1'b1; r.rw = 1'b1; end
            default: bad = 1'b1;
        endcase
        if (bad) begin r.il = 1'b1; r.rw = 1'b0; r.mw = 1'b0; end
        return r;
    endfunction

    // One clock cycle: check combinational outputs mid-cycle, advance the
    // reference, then check the ID/EX bundle just after the edge.
    task automatic step();
        bundle_t dec;
        bit is_m, e_start, e_ack, e_abort, e_stall;
        @(negedge clk);
        dec  = ref_decode(bus.opcode, bus.func3, bus.func7, bus.rd_d);
        is_m = EN_MULDIV && bus.opcode == 7'h33 && bus.func7 == 7'h01;
        e_start = 0; e_ack = 0; e_abort = 0; e_stall = 0;
        if (!rst) begin
            if (!m_busy) begin
                e_stall = bus.valid_d && is_m;
                e_start = e_stall && !bus.stall_e && !bus.flush_e;
            end else if (bus.flush_e) begin
                e_abort = 1; e_stall = 1;
            end else if (bus.muldiv_done && !bus.stall_e) begin
                e_ack = 1;
            end else begin
                e_stall = 1;
            end
        end
        s_start = bus.muldiv_start; s_ack = bus.muldiv_ack;
        s_abort = bus.muldiv_abort; s_stall_d = bus.stall_d;
        check("muldiv_start", 32'(s_start), 32'(e_start));
        check("muldiv_ack", 32'(s_ack), 32'(e_ack));
        check("muldiv_abort", 32'(s_abort), 32'(e_abort));
        check("stall_d", 32'(s_stall_d), 32'(e_stall));
        if (rst) begin
            m_e = '0; m_busy = 0;
        end else begin
            if (bus.flush_e) m_e = '0;
            else if (!bus.stall_e) begin
                if (e_ack) m_e = mk(1, 1, 0, 0, 0, 0, 0, 2'b11, 4'h0, 3'd0, m_rd);
                else if (bus.valid_d && !e_stall) m_e = dec;
                else m_e = '0;
            end
            if (e_start) begin m_busy = 1; m_rd = bus.rd_d; end
            else if (e_abort || e_ack) m_busy = 0;
        end
        @(posedge clk);
        #1;
        check("e_bundle", 32'(get_e()), 32'(m_e));
    endtask

    task automatic set_instr(input logic vd, input logic [6:0] op, input logic [2:0] f3,
                             input logic [6:0] f7, input logic [4:0] rd);
        bus.valid_d = vd; bus.opcode = op; bus.func3 = f3; bus.func7 = f7; bus.rd_d = rd;
    endtask

    // Behavioural MUL/DIV unit used during random traffic.
    task automatic md_tick();
        if (rst || s_ack || s_abort) begin
            u_busy = 0; bus.muldiv_done = 0;
        end else if (s_start) begin
            u_busy = 1; u_cnt = int'($urandom_range(0, 4));
        end
        if (u_busy && !bus.muldiv_done) begin
            if (u_cnt == 0) bus.muldiv_done = 1;
            else u_cnt--;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [6:0] ops [9];
        logic [6:0] f7s [4];
        bundle_t exp_ld;
        ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6f, 7'h67, 7'h37, 7'h0b};
        f7s = '{7'h00, 7'h20, 7'h01, 7'h55};

        addv(1, 7'h33, 3'd0, 7'h00, 5'd3,  mk(1,1,0,0,0,0,0,2'd0,4'h0,3'd0,5'd3));
        addv(1, 7'h33, 3'd0, 7'h20, 5'd4,  mk(1,1,0,0,0,0,0,2'd0,4'h1,3'd0,5'd4));
        addv(1, 7'h33, 3'd5, 7'h20, 5'd5,  mk(1,1,0,0,0,0,0,2'd0,4'h6,3'd0,5'd5));
        addv(1, 7'h33, 3'd3, 7'h00, 5'd6,  mk(1,1,0,0,0,0,0,2'd0,4'h3,3'd0,5'd6));
        addv(1, 7'h33, 3'd6, 7'h10, 5'd7,  mk(1,0,0,0,0,0,1,2'd0,4'h9,3'd0,5'd7));
        addv(1, 7'h33, 3'd4, 7'h00, 5'd14, mk(1,1,0,0,0,0,0,2'd0,4'hA,3'd0,5'd14));
        addv(1, 7'h33, 3'd7, 7'h20, 5'd15, mk(1,1,0,0,0,0,0,2'd0,4'h8,3'd0,5'd15));
        addv(1, 7'h13, 3'd0, 7'h55, 5'd8,  mk(1,1,0,1,0,0,0,2'd0,4'h0,3'd0,5'd8));
        addv(1, 7'h13, 3'd5, 7'h20, 5'd9,  mk(1,1,0,1,0,0,0,2'd0,4'h6,3'd0,5'd9));
        addv(1, 7'h13, 3'd1, 7'h20, 5'd10, mk(1,0,0,1,0,0,1,2'd0,4'h4,3'd0,5'd10));
        addv(1, 7'h03, 3'd2, 7'h00, 5'd11, mk(1,1,0,1,0,0,0,2'd1,4'h0,3'd0,5'd11));
        addv(1, 7'h23, 3'd2, 7'h00, 5'd7,  mk(1,0,1,1,0,0,0,2'd0,4'h0,3'd0,5'd7));
        addv(1, 7'h63, 3'd0, 7'h00, 5'd0,  mk(1,0,0,0,0,1,0,2'd0,4'h1,3'd0,5'd0));
        addv(1, 7'h63, 3'd5, 7'h00, 5'd3,  mk(1,0,0,0,0,1,0,2'd0,4'h1,3'd5,5'd3));
        addv(1, 7'h63, 3'd2, 7'h00, 5'd0,  mk(1,0,0,0,0,1,1,2'd0,4'h1,3'd2,5'd0));
        addv(1, 7'h6f, 3'd0, 7'h00, 5'd1,  mk(1,1,0,0,1,0,0,2'd2,4'h0,3'd0,5'd1));
        addv(1, 7'h67, 3'd0, 7'h00, 5'd2,  mk(1,1,0,1,1,0,0,2'd2,4'h0,3'd0,5'd2));
        addv(1, 7'h37, 3'd0, 7'h00, 5'd12, mk(1,1,0,1,0,0,0,2'd0,4'hF,3'd0,5'd12));
        addv(1, 7'h0b, 3'd0, 7'h00, 5'd13, mk(1,0,0,0,0,0,1,2'd0,4'h0,3'd0,5'd13));
        addv(0, 7'h33, 3'd0, 7'h00, 5'd3,  '0);

        m_e = '0; m_busy = 0; m_rd = '0; u_busy = 0; u_cnt = 0;
        set_instr(0, 7'h00, 3'd0, 7'h00, 5'd0);
        bus.stall_e = 0; bus.flush_e = 0; bus.muldiv_done = 0;

        @(posedge clk); #1;
        rst = 1;
        step(); step();
        check("reset_valid_e", 32'(bus.valid_e), 32'd0);
        rst = 0;

        foreach (vq[i]) begin
            set_instr(vq[i].vd, vq[i].op, vq[i].f3, vq[i].f7, vq[i].rd);
            step();
            check($sformatf("vec%0d", i), 32'(get_e()), 32'(vq[i].exp));
        end

        // MUL with done four cycles after start, then a back-to-back MUL.
        set_instr(1, 7'h33, 3'd0, 7'h01, 5'd5);
        step();
        check("mul_start", 32'(s_start), 32'd1);
        check("mul_stall_d", 32'(s_stall_d), 32'd1);
        check("mul_bubble", 32'(bus.valid_e), 32'd0);
        for (int k = 0; k < 3; k++) begin
            step();
            check("mul_wait_nostart", 32'(s_start), 32'd0);
            check("mul_wait_stall", 32'(s_stall_d), 32'd1);
            check("mul_wait_bubble", 32'(bus.valid_e), 32'd0);
        end
        bus.muldiv_done = 1;
        step();
        check("mul_ack", 32'(s_ack), 32'd1);
        check("mul_ack_stall", 32'(s_stall_d), 32'd0);
        check("mul_result", 32'(get_e()), 32'(mk(1,1,0,0,0,0,0,2'd3,4'h0,3'd0,5'd5)));
        bus.muldiv_done = 0;
        set_instr(1, 7'h33, 3'd4, 7'h01, 5'd6);
        step();
        check("b2b_start", 32'(s_start), 32'd1);
        bus.muldiv_done = 1;
        step();
        check("b2b_ack", 32'(s_ack), 32'd1);
        check("b2b_result", 32'(get_e()), 32'(mk(1,1,0,0,0,0,0,2'd3,4'h0,3'd0,5'd6)));
        bus.muldiv_done = 0;
        set_instr(0, 7'h00, 3'd0, 7'h00, 5'd0);
        step();
        check("mul_idle", 32'(s_stall_d), 32'd0);

        // Flush and done together while waiting: abort wins.
        set_instr(1, 7'h33, 3'd0, 7'h01, 5'd7);
        step(); step();
        bus.muldiv_done = 1; bus.flush_e = 1;
        step();
        check("flush_abort", 32'(s_abort), 32'd1);
        check("flush_noack", 32'(s_ack), 32'd0);
        check("flush_bubble", 32'(bus.valid_e), 32'd0);
        bus.muldiv_done = 0; bus.flush_e = 0;
        set_instr(0, 7'h00, 3'd0, 7'h00, 5'd0);
        step();
        check("flush_idle", 32'(s_stall_d), 32'd0);

        // stall_e holds a load for three cycles.
        set_instr(1, 7'h03, 3'd2, 7'h00, 5'd9);
        step();
        exp_ld = mk(1,1,0,1,0,0,0,2'd1,4'h0,3'd0,5'd9);
        check("ld_loaded", 32'(get_e()), 32'(exp_ld));
        bus.stall_e = 1;
        set_instr(1, 7'h33, 3'd0, 7'h00, 5'd4);
        for (int k = 0; k < 3; k++) begin
            step();
            check("ld_hold", 32'(get_e()), 32'(exp_ld));
        end
        bus.stall_e = 0;
        step();

        // Reset while waiting on MUL/DIV.
        set_instr(1, 7'h33, 3'd0, 7'h01, 5'd8);
        step(); step();
        rst = 1; bus.muldiv_done = 1;
        step();
        check("rst_nostart", 32'(s_start), 32'd0);
        check("rst_noack", 32'(s_ack), 32'd0);
        check("rst_noabort", 32'(s_abort), 32'd0);
        check("rst_zero", 32'(get_e()), 32'd0);
        rst = 0; bus.muldiv_done = 0;
        set_instr(0, 7'h00, 3'd0, 7'h00, 5'd0);
        step();
        check("rst_idle", 32'(s_stall_d), 32'd0);

        // Randomized traffic against the reference model.
        u_busy = 0; bus.muldiv_done = 0;
        s_stall_d = 0; s_start = 0; s_ack = 0; s_abort = 0;
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 99) == 0);
            bus.stall_e = ($urandom_range(0, 4) == 0);
            bus.flush_e = ($urandom_range(0, 15) == 0);
            if (!s_stall_d) begin
                set_instr($urandom_range(0, 3) != 0,
                          ($urandom_range(0, 7) == 0) ? 7'($urandom) : ops[$urandom_range(0, 8)],
                          3'($urandom),
                          ($urandom_range(0, 7) == 0) ? 7'($urandom) : f7s[$urandom_range(0, 3)],
                          5'($urandom));
            end
            step();
            md_tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
